tim_ctrl: RTL and testbench

TIM_CTRL -- requirements
Module: tim_ctrl

---
 rtl/tim_ctrl.sv | 139 +++++++++++++
 tb/tb_tim_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_ctrl.sv
// rtl/tim_ctrl.sv - timer control block: register file, IDLE/LOAD/RUN sequencer, update interrupt
// Optional feature: define TIM_CTRL_PRELOAD_EN to buffer PSC/ARR writes made during RUN until the next tim_done.
module tim_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  input  logic [15:0]       tim_cnt,
  input  logic              tim_done,
  output logic              timer_en,
  output logic [15:0]       tim_psc,
  output logic [15:0]       tim_arr,
  output logic              countdown,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PSC    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ARR    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CNT    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

  state_t      state, state_nxt;
  logic [3:0]  ctrl_q, ctrl_nxt;
  logic [15:0] psc_q, arr_q;
  logic        uif_q, uif_nxt;

  logic wr_ctrl, wr_psc, wr_arr, wr_status, done_run;

  assign wr_ctrl   = bus_wr && (bus_addr == A_CTRL);
  assign wr_psc    = bus_wr && (bus_addr == A_PSC);
  assign wr_arr    = bus_wr && (bus_addr == A_ARR);
  assign wr_status = bus_wr && (bus_addr == A_STATUS);
  assign done_run  = tim_done && (state == RUN);

  // Next CTRL value; a one-shot period end clears EN after any same-cycle write.
  always_comb begin
    ctrl_nxt = ctrl_q;
    if (wr_ctrl)
      ctrl_nxt = bus_wdata[3:0];
    if (done_run && ctrl_q[1])
      ctrl_nxt[0] = 1'b0;
  end

  // Set has priority over the W1C clear.
  always_comb begin
    uif_nxt = uif_q;
    if (wr_status && bus_wdata[0])
      uif_nxt = 1'b0;
    if (done_run)
      uif_nxt = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_ctrl && bus_wdata[0]) state_nxt = LOAD;
      LOAD:    state_nxt = ctrl_nxt[0] ? RUN : IDLE;
      RUN:     if (!ctrl_nxt[0]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctrl_q <= 4'd0;
      uif_q  <= 1'b0;
      psc_q  <= 16'd0;
      arr_q  <= 16'd0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_nxt;
      uif_q  <= uif_nxt;
      if (wr_psc) psc_q <= bus_wdata[15:0];
      if (wr_arr) arr_q <= bus_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tim_psc <= 16'd0;
      tim_arr <= 16'd0;
    end else begin
`ifdef TIM_CTRL_PRELOAD_EN
      if ((state == LOAD) || done_run) begin
        tim_psc <= psc_q;
        tim_arr <= arr_q;
      end
`else
      if (wr_psc)
        tim_psc <= bus_wdata[15:0];
      else if (state == LOAD)
        tim_psc <= psc_q;
      if (wr_arr)
        tim_arr <= bus_wdata[15:0];
      else if (state == LOAD)
        tim_arr <= arr_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_rdata <= 32'd0;
      bus_ack   <= 1'b0;
    end else begin
      bus_ack <= bus_wr | bus_rd;
      if (bus_rd) begin
        case (bus_addr)
          A_CTRL:   bus_rdata <= {28'd0, ctrl_q};
          A_PSC:    bus_rdata <= {16'd0, psc_q};
          A_ARR:    bus_rdata <= {16'd0, arr_q};
          A_CNT:    bus_rdata <= {16'd0, tim_cnt};
          A_STATUS: bus_rdata <= {31'd0, uif_q};
          default:  bus_rdata <= 32'd0;
        endcase
      end
    end
  end

  // Decoded from asynchronously reset state so reset drops these without a clock.
  assign timer_en  = (state == RUN);
  assign countdown = ctrl_q[3];
  assign irq       = uif_q & ctrl_q[2];

endmodule

// File: tb/tb_tim_ctrl.sv
// tb/tb_tim_ctrl.sv - directed self-checking bench for tim_ctrl
module tb_tim_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [2:0]  bus_addr = 3'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [15:0] tim_cnt = 16'd0;
  logic        tim_done = 1'b0;
  logic        timer_en;
  logic [15:0] tim_psc;
  logic [15:0] tim_arr;
  logic        countdown;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tim_ctrl #(.ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .tim_cnt(tim_cnt), .tim_done(tim_done),
    .timer_en(timer_en), .tim_psc(tim_psc), .tim_arr(tim_arr),
    .countdown(countdown), .irq(irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output logic ack);
    @(negedge clk);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr = 1'b0;
    ack = bus_ack;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk);
    bus_rd = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
    ack = bus_ack;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tim_done = 1'b1;
    @(negedge clk);
    tim_done = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({timer_en, irq, countdown, bus_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got en=%b irq=%b dn=%b ack=%b want 0000", timer_en, irq, countdown, bus_ack);
    end
    checks++;
    if ({tim_psc, tim_arr, bus_rdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_regs got psc=%h arr=%h rdata=%h want 0", tim_psc, tim_arr, bus_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_start();
    logic a1, a2, a3;
    bus_write(3'd1, 32'd9, a1);
    bus_write(3'd2, 32'd99, a2);
    bus_write(3'd0, 32'h1, a3);
    checks++;
    if ({a1, a2, a3} !== 3'b111) begin
      errors++; $display("FAIL start_ack got %b want 111", {a1, a2, a3});
    end
    checks++;
    if (timer_en !== 1'b0) begin
      errors++; $display("FAIL load_en got %b want 0", timer_en);
    end
    @(negedge clk);
    checks++;
    if ({timer_en, tim_psc, tim_arr} !== {1'b1, 16'd9, 16'd99}) begin
      errors++; $display("FAIL run_vals got en=%b psc=%0d arr=%0d want 1 9 99", timer_en, tim_psc, tim_arr);
    end
  endtask

  task automatic test_periodic();
    logic a;
    logic [31:0] d;
    bus_write(3'd0, 32'h5, a);
    checks++;
    if (timer_en !== 1'b1) begin
      errors++; $display("FAIL no_restart got en=%b want 1", timer_en);
    end
    pulse_done();
    checks++;
    if ({irq, timer_en} !== 2'b11) begin
      errors++; $display("FAIL periodic got irq=%b en=%b want 11", irq, timer_en);
    end
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL status_uif got %h want 00000001", d);
    end
    bus_write(3'd4, 32'h0, a);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL w0_status got irq=%b want 1", irq);
    end
    bus_write(3'd4, 32'h1, a);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL w1c got irq=%b want 0", irq);
    end
  endtask

  task automatic test_arr_update();
    logic a;
    logic [31:0] d;
    bus_write(3'd2, 32'd50, a);
`ifdef TIM_CTRL_PRELOAD_EN
    checks++;
    if (tim_arr !== 16'd99) begin
      errors++; $display("FAIL arr_shadow got %0d want 99", tim_arr);
    end
    pulse_done();
    bus_write(3'd4, 32'h1, a);
`endif
    checks++;
    if (tim_arr !== 16'd50) begin
      errors++; $display("FAIL arr_update got %0d want 50", tim_arr);
    end
    bus_read(3'd2, d, a);
    checks++;
    if (d !== 32'd50) begin
      errors++; $display("FAIL arr_read got %0d want 50", d);
    end
  endtask

  task automatic test_same_cycle();
    logic a;
    logic [31:0] d;
    @(negedge clk);
    tim_done = 1'b1; bus_wr = 1'b1; bus_addr = 3'd4; bus_wdata = 32'h1;
    @(negedge clk);
    tim_done = 1'b0; bus_wr = 1'b0;
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL set_wins got %h want 00000001", d);
    end
    bus_read(3'd6, d, a);
    checks++;
    if ({a, d} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL unmapped got ack=%b d=%h want 1 0", a, d);
    end
    tim_cnt = 16'h1234;
    bus_write(3'd3, 32'hFFFF, a);
    bus_read(3'd3, d, a);
    checks++;
    if (d !== 32'h1234) begin
      errors++; $display("FAIL cnt_read got %h want 00001234", d);
    end
    bus_write(3'd4, 32'h1, a);
  endtask

  task automatic test_oneshot();
    logic a;
    logic [31:0] d;
    bus_write(3'd0, 32'h3, a);
    pulse_done();
    checks++;
    if (timer_en !== 1'b0) begin
      errors++; $display("FAIL oneshot_en got %b want 0", timer_en);
    end
    bus_read(3'd0, d, a);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL oneshot_ctrl got %h want 00000002", d);
    end
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL oneshot_uif got %h want 00000001", d);
    end
    bus_write(3'd4, 32'h1, a);
    bus_write(3'd0, 32'h8, a);
    checks++;
    if ({countdown, timer_en} !== 2'b10) begin
      errors++; $display("FAIL dir got dn=%b en=%b want 10", countdown, timer_en);
    end
  endtask

  task automatic test_stop();
    logic a;
    logic [31:0] d;
    bus_write(3'd0, 32'h1, a);
    @(negedge clk);
    bus_write(3'd0, 32'h0, a);
    checks++;
    if (timer_en !== 1'b0) begin
      errors++; $display("FAIL stop got en=%b want 0", timer_en);
    end
    bus_write(3'd1, 32'hABCD0007, a);
    bus_read(3'd1, d, a);
    checks++;
    if (d !== 32'h7) begin
      errors++; $display("FAIL psc_upper got %h want 00000007", d);
    end
  endtask

  task automatic test_async_reset();
    logic a;
    logic [31:0] d;
    bus_write(3'd0, 32'h5, a);
    @(negedge clk);
    pulse_done();
    checks++;
    if ({timer_en, irq} !== 2'b11) begin
      errors++; $display("FAIL pre_reset got en=%b irq=%b want 11", timer_en, irq);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({timer_en, irq, tim_psc, tim_arr} !== 34'd0) begin
      errors++; $display("FAIL async_reset got en=%b irq=%b psc=%h arr=%h want 0", timer_en, irq, tim_psc, tim_arr);
    end
    @(negedge clk);
    reset = 1'b1;
    tim_cnt = 16'd0;
    for (int i = 0; i < 5; i++) begin
      bus_read(3'(i), d, a);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL post_reset_reg%0d got %h want 0", i, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_periodic();
    test_arr_update();
    test_same_cycle();
    test_oneshot();
    test_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
